// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// The request side uses req/gnt and the response side uses an rvalid strobe.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV32 memory stage: issues loads/stores on the dmem bus and holds the MEM/WB register.
// Stores granted in IDLE cost no stall; loads stall until rvalid; the stall bubbles writeback.
module mem_stage_lsu #(
    parameter logic [1:0] LOAD_SRC = 2'b01
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   MemWriteM,
    input  logic                   RegWriteM,
    input  logic [1:0]             ResultSrcM,
    input  logic [2:0]             Funct3M,
    input  logic [31:0]            ALUResultM,
    input  logic [31:0]            WriteDataM,
    input  logic [4:0]             RdM,
    input  logic [31:0]            PC_plus4M,
    mem_stage_lsu_if.master        dmem,
    output logic                   StallM,
    output logic                   MemFaultM,
    output logic                   RegWriteW,
    output logic [1:0]             ResultSrcW,
    output logic [31:0]            ALUResultW,
    output logic [31:0]            ReadDataW,
    output logic [4:0]             RdW,
    output logic [31:0]            PC_plus4W
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic        w_is_load;
    logic        w_access;
    logic        w_illegal_f3;
    logic        w_misaligned;
    logic        w_valid_access;
    logic        w_load_done;
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_off     = ALUResultM[1:0];
    assign w_is_load = (ResultSrcM == LOAD_SRC);
    assign w_access  = MemWriteM | w_is_load;

    always_comb begin
        w_illegal_f3 = 1'b0;
        if (MemWriteM) begin
            w_illegal_f3 = !(Funct3M inside {3'b000, 3'b001, 3'b010});
        end else begin
            w_illegal_f3 = !(Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
    end

    assign w_misaligned = ((Funct3M[1:0] == 2'b01) && w_off[0]) ||
                          ((Funct3M[1:0] == 2'b10) && (w_off != 2'b00));

    assign MemFaultM      = w_access & (w_illegal_f3 | w_misaligned);
    assign w_valid_access = w_access & !MemFaultM;

    // Bus fields are pure functions of the M inputs, which upstream freezes while stalled.
    assign dmem.dmem_addr = {ALUResultM[31:2], 2'b00};
    assign dmem.dmem_we   = MemWriteM;

    always_comb begin
        dmem.dmem_be    = 4'b0000;
        dmem.dmem_wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                dmem.dmem_be    = 4'b0001 << w_off;
                dmem.dmem_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                dmem.dmem_be    = 4'b0011 << {w_off[1], 1'b0};
                dmem.dmem_wdata = {2{WriteDataM[15:0]}};
            end
            2'b10: begin
                dmem.dmem_be    = 4'b1111;
                dmem.dmem_wdata = WriteDataM;
            end
            default: begin
                dmem.dmem_be    = 4'b0000;
                dmem.dmem_wdata = WriteDataM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        dmem.dmem_req = 1'b0;
        StallM        = 1'b0;
        w_load_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid_access) begin
                    dmem.dmem_req = 1'b1;
                    if (!dmem.dmem_gnt) begin
                        w_next_state = REQ;
                        StallM       = 1'b1;
                    end else if (!MemWriteM) begin
                        w_next_state = WAIT_R;
                        StallM       = 1'b1;
                    end
                end
            end
            REQ: begin
                dmem.dmem_req = 1'b1;
                if (!dmem.dmem_gnt) begin
                    StallM = 1'b1;
                end else if (MemWriteM) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT_R;
                    StallM       = 1'b1;
                end
            end
            WAIT_R: begin
                if (dmem.dmem_rvalid) begin
                    w_next_state = IDLE;
                    w_load_done  = 1'b1;
                end else begin
                    StallM = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        case (w_off)
            2'b00:   w_byte = dmem.dmem_rdata[7:0];
            2'b01:   w_byte = dmem.dmem_rdata[15:8];
            2'b10:   w_byte = dmem.dmem_rdata[23:16];
            default: w_byte = dmem.dmem_rdata[31:24];
        endcase
    end

    assign w_half = w_off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

    always_comb begin
        case (Funct3M)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = dmem.dmem_rdata;
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = 32'd0;
        endcase
    end

    // A stall cycle retires nothing: only RegWriteW drops, the rest hold for the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            RdW        <= 5'd0;
            PC_plus4W  <= 32'd0;
        end else if (!StallM) begin
            RegWriteW  <= RegWriteM & !MemFaultM;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= w_load_done ? w_load_data : 32'd0;
            RdW        <= RdM;
            PC_plus4W  <= PC_plus4M;
        end else begin
            RegWriteW  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stores, stalled loads, faults and reset mid-load.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic        MemWriteM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PC_plus4M;
    logic        StallM;
    logic        MemFaultM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PC_plus4W;

    int checks = 0;
    int errors = 0;
    int stall_cnt;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.LOAD_SRC(2'b01)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWriteM  (MemWriteM),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .PC_plus4M  (PC_plus4M),
        .dmem       (bus.master),
        .StallM     (StallM),
        .MemFaultM  (MemFaultM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .RdW        (RdW),
        .PC_plus4W  (PC_plus4W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mw, input logic rw, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc);
        MemWriteM  = mw;
        RegWriteM  = rw;
        ResultSrcM = rs;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        RdM        = rd;
        PC_plus4M  = pc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 5'd0, 32'd0);
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'd0;
        #22;
        chk("rst_req",      {31'd0, bus.dmem_req}, 32'd0);
        chk("rst_regwrite", {31'd0, RegWriteW},    32'd0);
        chk("rst_alures",   ALUResultW,            32'd0);
        chk("rst_stall",    {31'd0, StallM},       32'd0);
        rst_n = 1'b1;
        next_cycle();

        // SW 0x100 granted immediately: no stall
        drive(1'b1, 1'b0, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 32'h10);
        bus.dmem_gnt = 1'b1;
        #1;
        chk("sw_req",   {31'd0, bus.dmem_req}, 32'd1);
        chk("sw_we",    {31'd0, bus.dmem_we},  32'd1);
        chk("sw_addr",  bus.dmem_addr,         32'h100);
        chk("sw_be",    {28'd0, bus.dmem_be},  32'hF);
        chk("sw_wdata", bus.dmem_wdata,        32'hDEADBEEF);
        chk("sw_stall", {31'd0, StallM},       32'd0);
        next_cycle();

        // ADD follows store without a gap
        drive(1'b0, 1'b1, 2'b00, 3'b000, 32'h55, 32'd0, 5'd5, 32'h44);
        bus.dmem_gnt = 1'b0;
        #1;
        chk("add_stall", {31'd0, StallM},       32'd0);
        chk("add_req",   {31'd0, bus.dmem_req}, 32'd0);
        next_cycle();
        chk("add_regw",  {31'd0, RegWriteW}, 32'd1);
        chk("add_alu",   ALUResultW,         32'h55);
        chk("add_rd",    {27'd0, RdW},       32'd5);
        chk("add_rdata", ReadDataW,          32'd0);

        // LB 0x203: two cycles without grant, grant, one empty response cycle, then rvalid
        drive(1'b0, 1'b1, 2'b01, 3'b000, 32'h203, 32'd0, 5'd7, 32'h80);
        stall_cnt = 0;
        #1;
        chk("lb_addr", bus.dmem_addr,        32'h200);
        chk("lb_be",   {28'd0, bus.dmem_be}, 32'h8);
        chk("lb_we",   {31'd0, bus.dmem_we}, 32'd0);
        if (StallM) stall_cnt++;
        next_cycle();
        #1;
        chk("lb_req_wait", {31'd0, bus.dmem_req}, 32'd1);
        chk("lb_bubble",   {31'd0, RegWriteW},    32'd0);
        if (StallM) stall_cnt++;
        next_cycle();
        bus.dmem_gnt = 1'b1;
        #1;
        if (StallM) stall_cnt++;
        next_cycle();
        bus.dmem_gnt = 1'b0;
        #1;
        chk("lb_req_waitr", {31'd0, bus.dmem_req}, 32'd0);
        if (StallM) stall_cnt++;
        next_cycle();
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h80AABBCC;
        #1;
        chk("lb_stall_rv", {31'd0, StallM}, 32'd0);
        chk("lb_stall_cnt", stall_cnt, 32'd4);
        next_cycle();
        bus.dmem_rvalid = 1'b0;
        chk("lb_rdata", ReadDataW,          32'hFFFFFF80);
        chk("lb_regw",  {31'd0, RegWriteW}, 32'd1);
        chk("lb_rd",    {27'd0, RdW},       32'd7);
        chk("lb_alu",   ALUResultW,         32'h203);
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'd0, 5'd0, 32'h0);
        next_cycle();
        chk("lb_regw_once", {31'd0, RegWriteW}, 32'd0);

        // LHU 0x202 granted at once, data the following cycle
        drive(1'b0, 1'b1, 2'b01, 3'b101, 32'h202, 32'd0, 5'd9, 32'h90);
        bus.dmem_gnt = 1'b1;
        #1;
        chk("lhu_be",    {28'd0, bus.dmem_be}, 32'hC);
        chk("lhu_stall", {31'd0, StallM},      32'd1);
        next_cycle();
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h80011234;
        #1;
        chk("lhu_stall_rv", {31'd0, StallM}, 32'd0);
        next_cycle();
        bus.dmem_rvalid = 1'b0;
        chk("lhu_rdata", ReadDataW, 32'h00008001);

        // SH 0x202
        drive(1'b1, 1'b0, 2'b00, 3'b001, 32'h202, 32'h00001234, 5'd0, 32'hA0);
        bus.dmem_gnt = 1'b1;
        #1;
        chk("sh_be",    {28'd0, bus.dmem_be}, 32'hC);
        chk("sh_wdata", bus.dmem_wdata,       32'h12341234);
        chk("sh_stall", {31'd0, StallM},      32'd0);
        next_cycle();

        // Misaligned LW 0x102: flagged, never requested, retires without write
        drive(1'b0, 1'b1, 2'b01, 3'b010, 32'h102, 32'd0, 5'd3, 32'hB0);
        #1;
        chk("lw_fault", {31'd0, MemFaultM},    32'd1);
        chk("lw_req",   {31'd0, bus.dmem_req}, 32'd0);
        chk("lw_stall", {31'd0, StallM},       32'd0);
        next_cycle();
        chk("lw_regw",  {31'd0, RegWriteW}, 32'd0);
        chk("lw_rdata", ReadDataW,          32'd0);

        // Store with a load-only funct3 is illegal
        drive(1'b1, 1'b0, 2'b00, 3'b100, 32'h100, 32'h0, 5'd0, 32'hC0);
        #1;
        chk("sbu_fault", {31'd0, MemFaultM},    32'd1);
        chk("sbu_req",   {31'd0, bus.dmem_req}, 32'd0);
        next_cycle();

        // Reset while waiting for load data; the late rvalid must be ignored
        drive(1'b0, 1'b1, 2'b01, 3'b010, 32'h300, 32'd0, 5'd4, 32'hD0);
        bus.dmem_gnt = 1'b1;
        next_cycle();
        bus.dmem_gnt = 1'b0;
        #1;
        chk("rw_stall", {31'd0, StallM}, 32'd1);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'd0, 5'd0, 32'h0);
        #1;
        chk("rw_req",  {31'd0, bus.dmem_req}, 32'd0);
        chk("rw_pc4",  PC_plus4W,             32'd0);
        chk("rw_alu",  ALUResultW,            32'd0);
        next_cycle();
        #4;
        rst_n = 1'b1;
        next_cycle();
        drive(1'b0, 1'b1, 2'b00, 3'b000, 32'h77, 32'd0, 5'd6, 32'hE4);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hFFFFFFFF;
        #1;
        chk("post_stall", {31'd0, StallM},       32'd0);
        chk("post_req",   {31'd0, bus.dmem_req}, 32'd0);
        next_cycle();
        bus.dmem_rvalid = 1'b0;
        chk("post_regw",  {31'd0, RegWriteW}, 32'd1);
        chk("post_alu",   ALUResultW,         32'h77);
        chk("post_rdata", ReadDataW,          32'd0);
        chk("post_rd",    {27'd0, RdW},       32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory stage of the 5-stage RV32 pipeline. Consumes the EX/MEM register outputs, performs loads and stores on the data-memory bus via a req/gnt/rvalid handshake, stalls upstream while an access is outstanding, and contains the MEM/WB pipeline register that feeds writeback.

Parameters:
LOAD_SRC, 2'b01, ResultSrcM encoding that identifies a load (read data selected at writeback).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
MemWriteM  in  1  store request from EX/MEM register
RegWriteM  in  1  register-file write enable for this instruction
ResultSrcM  in  2  writeback source select; == LOAD_SRC marks a load
Funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
ALUResultM  in  32  effective address, or result for non-memory ops
WriteDataM  in  32  store data (unaligned, low bits valid)
RdM  in  5  destination register
PC_plus4M  in  32  link value for JAL/JALR
dmem_req  out  1  bus request valid
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  32  word-aligned address {ALUResultM[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  memory accepts request this cycle
dmem_rvalid  in  1  load data valid this cycle
dmem_rdata  in  32  load word
StallM  out  1  freeze PC/IF/ID/EX/EX-MEM registers (combinational)
MemFaultM  out  1  misaligned or illegal-funct3 access flag (combinational)
RegWriteW  out  1  MEM/WB register outputs follow
ResultSrcW  out  2  registered ResultSrcM
ALUResultW  out  32  registered ALUResultM
ReadDataW  out  32  extended load data; 0 for non-loads
RdW  out  5  registered RdM
PC_plus4W  out  32  registered PC_plus4M

Behaviour:
- access = MemWriteM | (ResultSrcM==LOAD_SRC). Fault: funct3 not in legal set for op (stores: 000/001/010 only), halfword with addr[0]=1, word with addr[1:0]!=0. Faulting access: no dmem_req, MemFaultM=1, no stall, retires with RegWriteW=0.
- FSM states IDLE, REQ, WAIT_R. dmem_req = (IDLE & access & !fault) | REQ. dmem_addr/we/be/wdata driven combinationally from M inputs (stable while stalled).
- IDLE: valid access & gnt & store -> stay IDLE, StallM=0 (zero-stall store). valid access & gnt & load -> WAIT_R, StallM=1. valid access & !gnt -> REQ, StallM=1. No access -> StallM=0.
- REQ: gnt & store -> IDLE, StallM=0; gnt & load -> WAIT_R, StallM=1; !gnt -> stay, StallM=1.
- WAIT_R: rvalid -> IDLE, StallM=0, extracted rdata loaded into ReadDataW on that edge; else stay, StallM=1. Min load latency: one stall cycle.
- dmem_rvalid outside WAIT_R ignored. dmem_gnt with dmem_req=0 ignored.
- Stores: SB be=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}; SH be=4'b0011<<{addr[1],0}, wdata={2{wd[15:0]}}; SW be=4'b1111, wdata=wd.
- Loads: byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
- MEM/WB register: StallM=0 -> load all W outputs (RegWriteW = RegWriteM & !MemFaultM); StallM=1 -> bubble: RegWriteW<=0, other W outputs hold.
- Reset (any time, incl. mid-transaction): state=IDLE, dmem_req=0, all W outputs 0; pending response after reset ignored.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt same cycle -> be=1111, wdata=0xDEADBEEF, StallM=0, no extra cycle.
- LB addr 0x203, gnt held 0 for 2 cycles then 1, rvalid 1 cycle later with rdata 0x80AABBCC -> StallM high 4 cycles, ReadDataW=0xFFFFFF80, RegWriteW=1 once.
- LHU addr 0x202 rdata 0x8001_1234 -> ReadDataW=0x00008001; SH addr 0x202 data 0x1234 -> be=1100, wdata=0x12341234.
- LW addr 0x102 -> MemFaultM=1, dmem_req=0, StallM=0, RegWriteW=0.
- rst_n low while in WAIT_R, rvalid arrives after release -> dmem_req=0, W outputs 0, rvalid ignored, next ADD passes in 1 cycle.
